pipe_hazard_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage RISC_TOY pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RISC_TOY pipeline.
// Shadows in-flight GPR writers (EX/MEM/WB) to drive stalls, flushes and forwarding selects.
module pipe_hazard_ctrl #(
  parameter int AW        = 5,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          id_valid,
  input  logic [AW-1:0] id_ra0,
  input  logic          id_use0,
  input  logic [AW-1:0] id_ra1,
  input  logic          id_use1,
  input  logic          id_wen,
  input  logic [AW-1:0] id_wa,
  input  logic          id_is_load,
  input  logic          ex_br_taken,
  input  logic          ext_hold,
  output logic          pc_hold,
  output logic          ifid_hold,
  output logic          idex_bubble,
  output logic          ifid_flush,
  output logic [1:0]    fwd0_sel,
  output logic [1:0]    fwd1_sel
);

  typedef struct packed {
    logic          v;
    logic          wen;
    logic [AW-1:0] wa;
    logic          ld;
  } entry_t;

  entry_t ex_q, mem_q, wb_q, id_entry;
  logic   ex_hit0, ex_hit1, luse;
  logic [1:0] sel0, sel1;

  function automatic logic hit(entry_t e, logic [AW-1:0] r, logic rd);
    return rd & e.v & e.wen & (e.wa == r);
  endfunction

  // Youngest matching writer decides; a load in EX never forwards from the ALU path.
  function automatic logic [1:0] pick_sel(entry_t ex_e, entry_t mem_e, entry_t wb_e,
                                          logic [AW-1:0] r, logic rd);
    logic [1:0] s;
    s = 2'd0;
    if (hit(ex_e, r, rd))
      s = ex_e.ld ? 2'd0 : 2'd1;
    else if (hit(mem_e, r, rd))
      s = 2'd2;
    else if (WB_BYPASS && hit(wb_e, r, rd))
      s = 2'd2;
    return s;
  endfunction

  always_comb begin
    id_entry    = {id_valid, id_wen, id_wa, id_is_load};
    ex_hit0     = hit(ex_q, id_ra0, id_use0);
    ex_hit1     = hit(ex_q, id_ra1, id_use1);
    luse        = id_valid & ex_q.ld & (ex_hit0 | ex_hit1) & ~ex_br_taken;
    sel0        = pick_sel(ex_q, mem_q, wb_q, id_ra0, id_use0);
    sel1        = pick_sel(ex_q, mem_q, wb_q, id_ra1, id_use1);
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    // Reset forces the pipeline controls quiet even if hold/branch inputs are active.
    if (!RSTN) begin
      pc_hold = 1'b0;
    end else if (ext_hold) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (luse) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      fwd0_sel <= 2'd0;
      fwd1_sel <= 2'd0;
    end else if (!ext_hold) begin
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q     <= idex_bubble ? '0 : id_entry;
      fwd0_sel <= idex_bubble ? 2'd0 : sel0;
      fwd1_sel <= idex_bubble ? 2'd0 : sel1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against an in-flight-list model.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
  localparam bit WB_BYPASS = 1'b1;

  logic CLK, RSTN;
  logic id_valid, id_use0, id_use1, id_wen, id_is_load, ex_br_taken, ext_hold;
  logic [AW-1:0] id_ra0, id_ra1, id_wa;
  logic pc_hold, ifid_hold, idex_bubble, ifid_flush;
  logic [1:0] fwd0_sel, fwd1_sel;

  pipe_hazard_ctrl #(.AW(AW), .WB_BYPASS(WB_BYPASS)) dut (
    .CLK(CLK), .RSTN(RSTN), .id_valid(id_valid), .id_ra0(id_ra0), .id_use0(id_use0),
    .id_ra1(id_ra1), .id_use1(id_use1), .id_wen(id_wen), .id_wa(id_wa),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .ext_hold(ext_hold),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .fwd0_sel(fwd0_sel), .fwd1_sel(fwd1_sel)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit v;
    bit wen;
    int wa;
    bit ld;
  } minst_t;

  // Index 0 is the youngest in-flight instruction (EX), 2 the oldest (WB).
  minst_t inflight[3];
  int exp_fwd0, exp_fwd1;
  int checks, errors;
  int obs_pc, obs_ifid, obs_bub, obs_flush;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) inflight[i] = '{0, 0, 0, 0};
    exp_fwd0 = 0;
    exp_fwd1 = 0;
  endtask

  function automatic int modelSel(int r, bit rd);
    if (!rd) return 0;
    for (int age = 0; age < 3; age++) begin
      if (inflight[age].v && inflight[age].wen && inflight[age].wa == r) begin
        if (age == 0) return inflight[0].ld ? 0 : 1;
        if (age == 1) return 2;
        return WB_BYPASS ? 2 : 0;
      end
    end
    return 0;
  endfunction

  task automatic applyStimulus(input bit v, input int ra0, input bit u0, input int ra1,
                               input bit u1, input bit wen, input int wa, input bit ld,
                               input bit br, input bit hold);
    bit load_use;
    int e_pc, e_ifid, e_bub, e_flush, n0, n1;
    minst_t incoming;
    id_valid = v; id_ra0 = AW'(ra0); id_use0 = u0; id_ra1 = AW'(ra1); id_use1 = u1;
    id_wen = wen; id_wa = AW'(wa); id_is_load = ld; ex_br_taken = br; ext_hold = hold;
    #1;
    load_use = v && inflight[0].v && inflight[0].wen && inflight[0].ld &&
               ((u0 && inflight[0].wa == ra0) || (u1 && inflight[0].wa == ra1));
    e_pc = 0; e_ifid = 0; e_bub = 0; e_flush = 0;
    if (hold) begin
      e_pc = 1; e_ifid = 1;
    end else if (br) begin
      e_flush = 1; e_bub = 1;
    end else if (load_use) begin
      e_pc = 1; e_ifid = 1; e_bub = 1;
    end
    obs_pc = int'(pc_hold); obs_ifid = int'(ifid_hold);
    obs_bub = int'(idex_bubble); obs_flush = int'(ifid_flush);
    checkOutput("pc_hold", obs_pc, e_pc);
    checkOutput("ifid_hold", obs_ifid, e_ifid);
    checkOutput("idex_bubble", obs_bub, e_bub);
    checkOutput("ifid_flush", obs_flush, e_flush);
    checkOutput("fwd0_sel", int'(fwd0_sel), exp_fwd0);
    checkOutput("fwd1_sel", int'(fwd1_sel), exp_fwd1);
    n0 = modelSel(ra0, u0);
    n1 = modelSel(ra1, u1);
    @(posedge CLK);
    #1;
    if (!hold) begin
      incoming = e_bub ? '{0, 0, 0, 0} : '{v, wen, wa, ld};
      inflight[2] = inflight[1];
      inflight[1] = inflight[0];
      inflight[0] = incoming;
      exp_fwd0 = e_bub ? 0 : n0;
      exp_fwd1 = e_bub ? 0 : n1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    modelReset();
    RSTN = 1'b0;
    id_valid = 0; id_ra0 = '0; id_use0 = 0; id_ra1 = '0; id_use1 = 0;
    id_wen = 0; id_wa = '0; id_is_load = 0; ex_br_taken = 1'b1; ext_hold = 1'b1;
    #3;
    checkOutput("rst_pc_hold", int'(pc_hold), 0);
    checkOutput("rst_ifid_hold", int'(ifid_hold), 0);
    checkOutput("rst_idex_bubble", int'(idex_bubble), 0);
    checkOutput("rst_ifid_flush", int'(ifid_flush), 0);
    checkOutput("rst_fwd0", int'(fwd0_sel), 0);
    checkOutput("rst_fwd1", int'(fwd1_sel), 0);
    ex_br_taken = 0; ext_hold = 0;
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] ALU back-to-back forward");
    applyStimulus(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 5, 1, 1, 4, 0, 0, 0);
    checkOutput("sub_no_stall", obs_pc, 0);
    checkOutput("sub_fwd0", int'(fwd0_sel), 1);
    idle(3);

    $display("[TB] load-use stall");
    applyStimulus(1, 2, 1, 0, 0, 1, 6, 1, 0, 0);
    applyStimulus(1, 6, 1, 6, 1, 1, 7, 0, 0, 0);
    checkOutput("lu_pc_hold", obs_pc, 1);
    checkOutput("lu_bubble", obs_bub, 1);
    applyStimulus(1, 6, 1, 6, 1, 1, 7, 0, 0, 0);
    checkOutput("lu_second_no_stall", obs_pc, 0);
    checkOutput("lu_fwd0", int'(fwd0_sel), 2);
    checkOutput("lu_fwd1", int'(fwd1_sel), 2);
    idle(3);

    $display("[TB] youngest writer");
    applyStimulus(1, 8, 1, 0, 0, 1, 8, 0, 0, 0);
    applyStimulus(1, 8, 1, 0, 0, 1, 8, 0, 0, 0);
    applyStimulus(1, 8, 1, 0, 0, 1, 9, 0, 0, 0);
    checkOutput("young_fwd0", int'(fwd0_sel), 1);
    idle(3);

    $display("[TB] flush beats stall");
    applyStimulus(1, 2, 1, 0, 0, 1, 6, 1, 0, 0);
    applyStimulus(1, 6, 1, 6, 1, 1, 7, 0, 1, 0);
    checkOutput("br_flush", obs_flush, 1);
    checkOutput("br_bubble", obs_bub, 1);
    checkOutput("br_pc_hold", obs_pc, 0);
    idle(3);

    $display("[TB] external hold mid-forward");
    applyStimulus(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 1, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4, 1, 1, 1, 1, 5, 1, 0, 1);
      checkOutput("hold_fwd0", int'(fwd0_sel), 1);
    end
    applyStimulus(1, 4, 1, 1, 1, 1, 5, 0, 0, 0);
    checkOutput("resume_fwd0", int'(fwd0_sel), 1);
    checkOutput("resume_fwd1", int'(fwd1_sel), 2);
    idle(3);

    $display("[TB] reset during load-use stall");
    applyStimulus(1, 2, 1, 0, 0, 1, 6, 1, 0, 0);
    id_valid = 1; id_ra0 = 6; id_use0 = 1; id_ra1 = 6; id_use1 = 1;
    id_wen = 1; id_wa = 7; id_is_load = 0;
    #1;
    checkOutput("pre_rst_stall", int'(pc_hold), 1);
    RSTN = 1'b0;
    ext_hold = 1'b1;
    #1;
    checkOutput("mid_rst_pc_hold", int'(pc_hold), 0);
    checkOutput("mid_rst_ifid_hold", int'(ifid_hold), 0);
    checkOutput("mid_rst_bubble", int'(idex_bubble), 0);
    checkOutput("mid_rst_flush", int'(ifid_flush), 0);
    checkOutput("mid_rst_fwd0", int'(fwd0_sel), 0);
    checkOutput("mid_rst_fwd1", int'(fwd1_sel), 0);
    modelReset();
    id_valid = 0; id_use0 = 0; id_use1 = 0; id_wen = 0; id_is_load = 0; ext_hold = 0;
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    applyStimulus(1, 6, 1, 6, 1, 1, 7, 0, 0, 0);
    checkOutput("post_rst_no_stall", obs_pc, 0);
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom % 8) != 0, $urandom_range(0, 3), $urandom % 2,
                    $urandom_range(0, 3), $urandom % 2, ($urandom % 4) != 0,
                    $urandom_range(0, 3), ($urandom % 3) == 0, ($urandom % 10) == 0,
                    ($urandom % 8) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
